// File: rtl/seq_cla_adder.sv
// rtl/seq_cla_adder.sv - multi-cycle carry-look-ahead adder/subtractor, one CLA slice per clock
module seq_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NG = WIDTH / GROUP;
    localparam int IW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NG - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({GROUP{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;

    int               slice_off;
    logic [GROUP-1:0] sa, sb, g, p, s;
    logic [GROUP:0]   c;
    logic             acc, prod;

    assign slice_off = int'(idx_q) * GROUP;
    assign sa = GROUP'(a_q >> slice_off);
    assign sb = GROUP'(b_q >> slice_off);

    // One CLA slice: every carry is a flat sum of products of g, p and the slice carry-in
    always_comb begin
        g    = sa & sb;
        p    = sa ^ sb;
        c    = '0;
        acc  = 1'b0;
        prod = 1'b0;
        c[0] = carry_q;
        for (int i = 0; i < GROUP; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                acc = acc | prod;
            end
            prod = carry_q;
            for (int k = 0; k <= i; k++) begin
                prod = prod & p[k];
            end
            c[i+1] = acc | prod;
        end
        s = p ^ c[GROUP-1:0];
    end

    // Next-state: latch operands in IDLE, resolve one slice per RUN cycle, hold result in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{sub}};
                    carry_d = sub | Cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(SLICE_MASK << slice_off)) | (WIDTH'(s) << slice_off);
                carry_d = c[GROUP];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = c[GROUP];
                    ovf_d   = c[GROUP] ^ c[GROUP-1];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_seq_cla_adder.sv
// tb/tb_seq_cla_adder.sv - randomized and directed bench for seq_cla_adder at widths 4, 16 and 32
module tb_seq_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv     [3];
    logic        or_in  [3];
    logic [31:0] a_in   [3];
    logic [31:0] b_in   [3];
    logic        cin_in [3];
    logic        sub_in [3];
    logic [2:0]  rdy, ov, co, of;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [31:0] sum32;
    logic [31:0] sums   [3];

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    bit          m_busy [3];
    int          m_cnt  [3];
    logic [31:0] m_sum  [3];
    logic        m_cout [3];
    logic        m_ovf  [3];

    always #5 clk = ~clk;

    seq_cla_adder #(.WIDTH(4), .GROUP(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
        .A(a_in[0][3:0]), .B(b_in[0][3:0]), .Cin(cin_in[0]), .sub(sub_in[0]),
        .out_valid(ov[0]), .out_ready(or_in[0]), .Sum(sum4), .Cout(co[0]), .Ovf(of[0])
    );
    seq_cla_adder #(.WIDTH(16), .GROUP(4)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
        .A(a_in[1][15:0]), .B(b_in[1][15:0]), .Cin(cin_in[1]), .sub(sub_in[1]),
        .out_valid(ov[1]), .out_ready(or_in[1]), .Sum(sum16), .Cout(co[1]), .Ovf(of[1])
    );
    seq_cla_adder #(.WIDTH(32), .GROUP(4)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
        .A(a_in[2]), .B(b_in[2]), .Cin(cin_in[2]), .sub(sub_in[2]),
        .out_valid(ov[2]), .out_ready(or_in[2]), .Sum(sum32), .Cout(co[2]), .Ovf(of[2])
    );

    assign sums[0] = {28'b0, sum4};
    assign sums[1] = {16'b0, sum16};
    assign sums[2] = sum32;

    function automatic int wd(int i);
        return (i == 0) ? 4 : ((i == 1) ? 16 : 32);
    endfunction

    function automatic int ng(int i);
        return wd(i) / 4;
    endfunction

    // Reference: {ovf, cout, sum} by plain wide arithmetic and sign comparison
    function automatic logic [33:0] ref_add(int w, logic [31:0] a, logic [31:0] b, logic cin, logic s);
        logic [63:0] m, am, bm, full;
        logic [31:0] sm;
        logic        cy, ovf;
        m    = (64'd1 << w) - 64'd1;
        am   = {32'b0, a} & m;
        bm   = (s ? ~{32'b0, b} : {32'b0, b}) & m;
        full = am + bm + {63'b0, (s | cin)};
        sm   = full[31:0] & m[31:0];
        cy   = full[w];
        ovf  = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
        return {ovf, cy, sm};
    endfunction

    task automatic chk(string name, int i, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got=%h expected=%h", name, i, got, exp);
        end
    endtask

    // Transaction-level model: accept, count NG cycles, then wait for out_ready
    always @(posedge clk) begin
        logic [33:0] r;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] = 0;
                m_cnt[i]  = 0;
            end else if (!m_busy[i]) begin
                if (iv[i]) begin
                    r         = ref_add(wd(i), a_in[i], b_in[i], cin_in[i], sub_in[i]);
                    m_busy[i] = 1;
                    m_cnt[i]  = 0;
                    m_sum[i]  = r[31:0];
                    m_cout[i] = r[32];
                    m_ovf[i]  = r[33];
                end
            end else if (m_cnt[i] < ng(i)) begin
                m_cnt[i] = m_cnt[i] + 1;
            end else if (or_in[i]) begin
                m_busy[i] = 0;
            end
        end
    end

    // Compare every DUT against the model on each falling edge
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk("out_valid", i, {31'b0, ov[i]}, {31'b0, (m_busy[i] && m_cnt[i] == ng(i))});
                chk("in_ready", i, {31'b0, rdy[i]}, {31'b0, (!m_busy[i] && !rst)});
                if (m_busy[i] && m_cnt[i] == ng(i)) begin
                    chk("model_sum", i, sums[i], m_sum[i]);
                    chk("model_cout", i, {31'b0, co[i]}, {31'b0, m_cout[i]});
                    chk("model_ovf", i, {31'b0, of[i]}, {31'b0, m_ovf[i]});
                end
            end
        end
    end

    task automatic do_op(int i, logic [31:0] a, logic [31:0] b, logic cin, logic s,
                         bit lit, logic [31:0] es, logic ec, logic eo, int hold, bit early);
        int          k;
        int          lat;
        bit          got;
        logic [31:0] snap;
        @(posedge clk); #2;
        iv[i] = 1'b1; a_in[i] = a; b_in[i] = b; cin_in[i] = cin; sub_in[i] = s; or_in[i] = 1'b0;
        got = 0;
        for (k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rdy[i]) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", i, 32'd0, 32'd1);
            iv[i] = 1'b0;
            return;
        end
        @(posedge clk); #2;
        iv[i] = 1'b0;
        a_in[i] = $urandom; b_in[i] = $urandom; cin_in[i] = 1'($urandom); sub_in[i] = 1'($urandom);
        if (early) or_in[i] = 1'b1;
        got = 0;
        for (k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ov[i]) got = 1;
        end
        if (!got) begin
            chk("result_timeout", i, 32'd0, 32'd1);
            or_in[i] = 1'b0;
            return;
        end
        lat = k - 1;
        chk("latency", i, lat, ng(i));
        if (lit) begin
            chk("lit_sum", i, sums[i], es);
            chk("lit_cout", i, {31'b0, co[i]}, {31'b0, ec});
            chk("lit_ovf", i, {31'b0, of[i]}, {31'b0, eo});
        end
        snap = sums[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", i, {31'b0, ov[i]}, 32'd1);
            chk("hold_ready", i, {31'b0, rdy[i]}, 32'd0);
            chk("hold_sum", i, sums[i], snap);
        end
        or_in[i] = 1'b1;
        @(posedge clk); #2;
        or_in[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; or_in[i] = 1'b0; a_in[i] = '0; b_in[i] = '0; cin_in[i] = 1'b0; sub_in[i] = 1'b0;
        end
        @(posedge clk); #2;
        started = 1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_sum", i, sums[i], 32'd0);
            chk("rst_cout", i, {31'b0, co[i]}, 32'd0);
            chk("rst_ovf", i, {31'b0, of[i]}, 32'd0);
            chk("rst_ready", i, {31'b0, rdy[i]}, 32'd0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("post_rst_ready", i, {31'b0, rdy[i]}, 32'd1);

        do_op(1, 32'h0001, 32'h0000, 1'b0, 1'b0, 1, 32'h0001, 1'b0, 1'b0, 0, 0);
        do_op(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1, 32'h0000, 1'b1, 1'b0, 0, 0);
        do_op(1, 32'h000B, 32'h0006, 1'b1, 1'b0, 1, 32'h0012, 1'b0, 1'b0, 0, 1);
        do_op(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 1, 32'h8000, 1'b0, 1'b1, 0, 0);
        do_op(1, 32'h8000, 32'h0001, 1'b0, 1'b1, 1, 32'h7FFF, 1'b1, 1'b1, 0, 0);
        do_op(1, 32'h0005, 32'h0003, 1'b0, 1'b1, 1, 32'h0002, 1'b1, 1'b0, 0, 0);
        do_op(1, 32'h0003, 32'h0005, 1'b0, 1'b1, 1, 32'hFFFE, 1'b0, 1'b0, 0, 0);
        do_op(1, 32'h0005, 32'h0003, 1'b1, 1'b1, 1, 32'h0002, 1'b1, 1'b0, 0, 0);
        do_op(1, 32'h0003, 32'h0005, 1'b1, 1'b1, 1, 32'hFFFE, 1'b0, 1'b0, 10, 0);
        do_op(0, 32'hF, 32'h1, 1'b0, 1'b0, 1, 32'h0, 1'b1, 1'b0, 0, 0);
        do_op(2, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1, 32'h0, 1'b1, 1'b0, 0, 0);
        do_op(2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1, 32'h80000000, 1'b0, 1'b1, 2, 0);

        // Abort mid-RUN: rst asserted during the second RUN cycle
        @(posedge clk); #2;
        iv[1] = 1'b1; a_in[1] = 32'h1234; b_in[1] = 32'h4321; cin_in[1] = 1'b0; sub_in[1] = 1'b0;
        @(posedge clk); #2;
        iv[1] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", 1, {31'b0, ov[1]}, 32'd0);
        chk("abort_sum", 1, sums[1], 32'd0);
        chk("abort_cout", 1, {31'b0, co[1]}, 32'd0);
        chk("abort_ready", 1, {31'b0, rdy[1]}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 1, {31'b0, rdy[1]}, 32'd1);
        do_op(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1, 32'h0000, 1'b1, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int  i;
            bit  e;
            i = $urandom_range(0, 2);
            e = 1'($urandom);
            do_op(i, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, 32'd0, 1'b0, 1'b0,
                  e ? 0 : $urandom_range(0, 3), e);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
